// File: rtl/ps2_player_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : ps2_player_dispatcher
// Brief    : Parses PS/2 scancodes, filters auto-repeat, and queues arrow
//            presses into per-player FWFT FIFOs with valid/ack handoff.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_player_dispatcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          ps2_key_pressed,
   input  logic [7:0]    ps2_out,
   input  logic          p1_ack,
   input  logic          p2_ack,
   output logic          p1_valid,
   output logic [2:0]    p1_arrow,
   output logic          p2_valid,
   output logic [2:0]    p2_arrow,
   output logic [CW-1:0] p1_count,
   output logic [CW-1:0] p2_count,
   output logic          p1_overflow,
   output logic          p2_overflow
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] c_idle    = 2'd0;
   localparam logic [1:0] c_brk     = 2'd1;
   localparam logic [1:0] c_ext     = 2'd2;
   localparam logic [1:0] c_ext_brk = 2'd3;

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_held;
   logic       w_ext;
   logic       w_hit;
   logic [2:0] w_idx;
   logic [2:0] w_code;
   logic       w_prefix;
   logic       w_make;
   logic       w_release;
   logic       w_press;

   assign w_ext     = (r_state == c_ext) || (r_state == c_ext_brk);
   assign w_prefix  = (ps2_out == 8'hF0) || (ps2_out == 8'hE0);
   assign w_make    = ps2_key_pressed && !w_prefix
                      && ((r_state == c_idle) || (r_state == c_ext));
   assign w_release = ps2_key_pressed
                      && ((r_state == c_brk) || (r_state == c_ext_brk));
   assign w_press   = w_make && w_hit && !r_held[w_idx];
   assign w_code    = {1'b0, w_idx[1:0]} + 3'd1;

   // Index bit 2 selects the owning player; bits 1:0 are arrow code minus one.
   always_comb begin
      w_hit = 1'b0;
      w_idx = 3'd0;
      case (ps2_out)
         8'h1D: begin w_hit = !w_ext; w_idx = 3'd0; end
         8'h1C: begin w_hit = !w_ext; w_idx = 3'd1; end
         8'h1B: begin w_hit = !w_ext; w_idx = 3'd2; end
         8'h23: begin w_hit = !w_ext; w_idx = 3'd3; end
         8'h75: begin w_hit = 1'b1;   w_idx = 3'd4; end
         8'h6B: begin w_hit = 1'b1;   w_idx = 3'd5; end
         8'h72: begin w_hit = 1'b1;   w_idx = 3'd6; end
         8'h74: begin w_hit = 1'b1;   w_idx = 3'd7; end
         default: begin w_hit = 1'b0; w_idx = 3'd0; end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      if (ps2_key_pressed) begin
         case (r_state)
            c_idle: begin
               if (ps2_out == 8'hF0)      w_state_nxt = c_brk;
               else if (ps2_out == 8'hE0) w_state_nxt = c_ext;
               else                       w_state_nxt = c_idle;
            end
            c_ext: begin
               if (ps2_out == 8'hF0)      w_state_nxt = c_ext_brk;
               else if (ps2_out == 8'hE0) w_state_nxt = c_ext;
               else                       w_state_nxt = c_idle;
            end
            default: w_state_nxt = c_idle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_idle;
         r_held  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_press)
            r_held[w_idx] <= 1'b1;
         else if (w_release && w_hit)
            r_held[w_idx] <= 1'b0;
      end
   end

   logic [1:0]         w_ack;
   logic [1:0]         w_valid;
   logic [1:0][2:0]    w_arrow;
   logic [1:0][CW-1:0] w_count;
   logic [1:0]         w_ovf;

   assign w_ack = {p2_ack, p1_ack};

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [2:0]    r_mem [FIFO_DEPTH];
      logic [AW-1:0] r_wr;
      logic [AW-1:0] r_rd;
      logic [CW-1:0] r_cnt;
      logic          r_ovf;
      logic          w_req;
      logic          w_pop;
      logic          w_full;
      logic          w_push;

      assign w_req  = w_press && (w_idx[2] == 1'(g));
      assign w_pop  = w_ack[g] && (r_cnt != '0);
      assign w_full = (r_cnt == CW'(FIFO_DEPTH));
      // A pop frees the slot in the same cycle, so a full queue may still accept.
      assign w_push = w_req && (!w_full || w_pop);

      always_ff @(posedge clock) begin
         if (w_push)
            r_mem[r_wr] <= w_code;
      end

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else begin
            if (w_push)
               r_wr <= r_wr + AW'(1);
            if (w_pop)
               r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_req && w_full && !w_pop)
               r_ovf <= 1'b1;
         end
      end

      assign w_valid[g] = (r_cnt != '0);
      assign w_arrow[g] = w_valid[g] ? r_mem[r_rd] : 3'd0;
      assign w_count[g] = r_cnt;
      assign w_ovf[g]   = r_ovf;
   end

   assign p1_valid    = w_valid[0];
   assign p2_valid    = w_valid[1];
   assign p1_arrow    = w_arrow[0];
   assign p2_arrow    = w_arrow[1];
   assign p1_count    = w_count[0];
   assign p2_count    = w_count[1];
   assign p1_overflow = w_ovf[0];
   assign p2_overflow = w_ovf[1];

endmodule
`default_nettype wire

// File: doc/ps2_player_dispatcher.md
Name: ps2_player_dispatcher

Overview:
Shares the single PS2_Interface byte stream between the two player processors. It parses make, break and E0-extended scancodes, maps arrow keys to the owning player, and suppresses typematic auto-repeat. Each accepted press is queued in a per-player FIFO and handed to that player's processor over a valid/ack handshake. It sits between PS2_Interface and the two processor ps2_key_pressed/ps2_out inputs, replacing the combinational key decode.

Parameters:
FIFO_DEPTH, 4, entries per player queue; power of two, 2..16
CW, $clog2(FIFO_DEPTH)+1, occupancy count width (derived, not overridden)

Ports:
clock  in  1  system clock (the 10 MHz pll output)
resetn  in  1  asynchronous, active-low reset
ps2_key_pressed  in  1  one-cycle strobe; ps2_out holds a new byte in that cycle
ps2_out  in  8  received scancode byte
p1_ack  in  1  player-1 processor consumes the head entry
p2_ack  in  1  player-2 processor consumes the head entry
p1_valid  out  1  player-1 FIFO not empty
p1_arrow  out  3  player-1 head arrow code: 001 up, 010 left, 011 down, 100 right
p2_valid  out  1  player-2 FIFO not empty
p2_arrow  out  3  player-2 head arrow code, same encoding
p1_count  out  CW  player-1 occupancy, 0..FIFO_DEPTH
p2_count  out  CW  player-2 occupancy, 0..FIFO_DEPTH
p1_overflow  out  1  sticky: a player-1 press was dropped because the FIFO was full
p2_overflow  out  1  sticky: a player-2 press was dropped because the FIFO was full

Behaviour:
- Reset (resetn=0, asynchronous): parser to IDLE, FIFOs empty, all held bits clear. All outputs 0; arrow outputs 000.
- Bytes are processed only in cycles where ps2_key_pressed=1. The parser state changes on no other cycle.
- Key map:
  - Player 1: 1D up, 1C left, 1B down, 23 right.
  - Player 2: 75 up, 6B left, 72 down, 74 right, accepted with or without the E0 prefix.
  - Player-1 codes received after E0 are ignored.
- Parser FSM, states IDLE, BRK, EXT, EXT_BRK:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code; evaluate it, stay in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte is an extended make; evaluate it, -> IDLE.
  - BRK, EXT_BRK: the next byte is a release; clear the matching held bit (if any) -> IDLE.
- Held register: 8 bits, one per player-arrow.
  - A mapped make whose held bit is 0 is a press: set the bit, push the code to the owner's FIFO.
  - A mapped make whose held bit is 1 is auto-repeat: discard it.
  - Unmapped make or release bytes: no effect beyond the state transition.
- Latency: a strobe in cycle N with a mapped press into an empty FIFO gives valid=1 with the correct arrow in cycle N+1.
- FIFOs are first-word fall-through. The arrow output always shows the head entry, and shows 000 when empty.
  - Pop when ack=1 and valid=1. Ack while valid=0 is ignored.
  - Push and pop in the same cycle, not full: both occur, count unchanged.
  - Push when full with no pop: the entry is dropped and overflow is set. Overflow clears only on reset.
  - Push when full with a pop in the same cycle: both occur, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- At most one push per cycle in total (one byte per cycle). The two players' pops are independent and may occur in the same cycle.
- Held bits are set even if the push is dropped, so a full FIFO does not let auto-repeat refill later.
- Reset mid-sequence (e.g. after F0): the partial sequence is discarded; the next byte is parsed from IDLE.

Test Plan:
- Press 1D once, then 1C, 23 strobed over separate cycles, p1_ack=0 -> p1_count=3, p1_arrow=001; three acks yield 001, 010, 100, then p1_valid=0; p2 side unchanged.
- E0 75, then plain 6B -> p2 FIFO holds 001 then 010; E0 1D pushes nothing.
- 1B, 1B, 1B (typematic), F0 1B, 1B -> exactly two player-1 entries of 011.
- Five distinct player-2 presses with FIFO_DEPTH=4 and no ack -> p2_count=4, p2_overflow=1; with count=4, a press and p2_ack in the same cycle -> count stays 4 and the head advances.
- Pulse resetn low between F0 and 1C -> all outputs 0; next byte 1C is treated as a press (p1_arrow=010).
- Simultaneous p1_ack and p2_ack with both non-empty -> both counts decrement by 1; ack while empty -> no change.
